// File: rtl/nios2_spi_slave.sv
`default_nettype none
// nios2_spi_slave: 8-bit MSB-first CPOL0/CPHA0 SPI target with a CPU register port
// whose register map and interrupt scheme mirror the nios2_spi master.
module nios2_spi_slave (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    output logic        MISO,
    output logic        MISO_oe
);
    localparam logic [15:0] IRQ_MASK = 16'h03D8;

    logic       sclk_s1, sclk_s2, sclk_d;
    logic       mosi_s1, mosi_s2;
    logic       ss_s1, ss_s2, ss_d;
    logic       active, busy, rx_bit;
    logic [2:0] bitcnt;
    logic [7:0] shift_reg, rx_holding, tx_holding, eop_value;
    logic       tx_primed, rrdy, roe, toe, eop;
    logic [15:0] control;
    logic       rd_strobe, wr_strobe;

    logic       sclk_rise, sclk_fall, ss_fall, ss_rise, spi_rise, spi_fall;
    logic       byte_done, tx_load, wr_tx, wr_status, rd_rx, tx_accept;
    logic [15:0] status, read_mux;

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign ss_fall   = ~ss_s2 & ss_d;
    assign ss_rise   = ss_s2 & ~ss_d;
    assign spi_rise  = active & ~ss_rise & sclk_rise;
    assign spi_fall  = active & ~ss_rise & sclk_fall;
    assign byte_done = spi_rise & (bitcnt == 3'd7);
    assign tx_load   = ss_fall | (spi_fall & (bitcnt == 3'd0));
    assign wr_tx     = wr_strobe & (mem_addr == 3'd1);
    assign wr_status = wr_strobe & (mem_addr == 3'd2);
    assign rd_rx     = rd_strobe & (mem_addr == 3'd0);
    // A write landing on the same cycle as a load may refill the slot just emptied.
    assign tx_accept = wr_tx & (~tx_primed | tx_load);

    assign status = {6'b0, eop, roe | toe, rrdy, ~tx_primed, ~tx_primed & ~busy,
                     toe, roe, 3'b0};
    assign MISO    = shift_reg[7];
    assign MISO_oe = active;

    always_comb begin
        read_mux = 16'h0000;
        case (mem_addr)
            3'd0:    read_mux = {8'h00, rx_holding};
            3'd2:    read_mux = status;
            3'd3:    read_mux = control;
            3'd6:    read_mux = {8'h00, eop_value};
            default: read_mux = 16'h0000;
        endcase
    end

    // Sync flops reset low so a select already active at reset release never
    // produces a fall; the block waits for SS_n to rise first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0;
            mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
            ss_s1   <= 1'b0; ss_s2   <= 1'b0; ss_d   <= 1'b0;
        end else begin
            sclk_s1 <= SCLK;   sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
            mosi_s1 <= MOSI;   mosi_s2 <= mosi_s1;
            ss_s1   <= SS_n;   ss_s2   <= ss_s1;   ss_d   <= ss_s2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active     <= 1'b0;
            busy       <= 1'b0;
            bitcnt     <= 3'd0;
            rx_bit     <= 1'b0;
            rx_holding <= 8'h00;
            shift_reg  <= 8'h00;
        end else begin
            if (ss_rise) begin
                active <= 1'b0;
                busy   <= 1'b0;
                bitcnt <= 3'd0;
            end else if (ss_fall) begin
                active <= 1'b1;
                busy   <= 1'b1;
                bitcnt <= 3'd0;
            end else if (spi_rise) begin
                rx_bit <= mosi_s2;
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    rx_holding <= {shift_reg[6:0], mosi_s2};
                    busy       <= 1'b0;
                end
            end
            if (tx_load)
                shift_reg <= tx_primed ? tx_holding : 8'h00;
            else if (spi_fall)
                shift_reg <= {shift_reg[6:0], rx_bit};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_strobe   <= 1'b0;
            wr_strobe   <= 1'b0;
            data_to_cpu <= 16'h0000;
            tx_holding  <= 8'h00;
            tx_primed   <= 1'b0;
            rrdy        <= 1'b0;
            roe         <= 1'b0;
            toe         <= 1'b0;
            eop         <= 1'b0;
            eop_value   <= 8'h00;
            control     <= 16'h0000;
            irq         <= 1'b0;
        end else begin
            rd_strobe <= spi_select & ~read_n & ~rd_strobe;
            wr_strobe <= spi_select & ~write_n & ~wr_strobe;
            if (spi_select & ~read_n & ~rd_strobe)
                data_to_cpu <= read_mux;

            if (tx_accept) begin
                tx_holding <= data_from_cpu[7:0];
                tx_primed  <= 1'b1;
            end else if (tx_load) begin
                tx_primed  <= 1'b0;
            end

            // Byte completion outranks a clearing read or status write for RRDY.
            if (byte_done)
                rrdy <= 1'b1;
            else if (rd_rx | wr_status)
                rrdy <= 1'b0;

            if (wr_status)
                roe <= 1'b0;
            else if (byte_done & rrdy)
                roe <= 1'b1;

            if (wr_status)
                toe <= 1'b0;
            else if (wr_tx & ~tx_accept)
                toe <= 1'b1;

            if (wr_status)
                eop <= 1'b0;
            else if ((rd_rx & (rx_holding == eop_value)) |
                     (wr_tx & (data_from_cpu[7:0] == eop_value)))
                eop <= 1'b1;

            if (wr_strobe & (mem_addr == 3'd6))
                eop_value <= data_from_cpu[7:0];
            if (wr_strobe & (mem_addr == 3'd3))
                control <= data_from_cpu & IRQ_MASK;

            irq <= |(status & control & IRQ_MASK);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_nios2_spi_slave.sv
`default_nettype none
// tb_nios2_spi_slave: directed, table-driven check of the SPI slave against
// hand-computed expectations, plus multi-byte, error-flag and abort sequences.
module tb_nios2_spi_slave;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_select = 1'b0;
    logic [2:0]  mem_addr = 3'd0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [15:0] data_from_cpu = 16'h0000;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        SS_n = 1'b1;
    logic        MISO;
    logic        MISO_oe;

    int total = 0;
    int passed = 0;

    nios2_spi_slave dut (
        .clk(clk), .reset_n(reset_n), .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
        .MISO(MISO), .MISO_oe(MISO_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          prime;
        logic [7:0]  tx;
        logic [7:0]  mosi;
        logic [7:0]  exp_miso;
        logic [15:0] exp_st_full;
        logic [15:0] exp_rx;
        logic [15:0] exp_st_after;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        clks(2);
        spi_select = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
        clks(2);
        d = data_to_cpu;
        spi_select = 1'b0; read_n = 1'b1;
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            MOSI = mo[i];
            clks(4);
            got[i] = MISO;
            SCLK = 1'b1;
            clks(4);
            SCLK = 1'b0;
        end
    endtask

    task automatic ss_low();
        SS_n = 1'b0;
        clks(4);
    endtask

    task automatic ss_high();
        clks(4);
        SS_n = 1'b1;
        clks(6);
    endtask

    initial begin
        vec_t        vecs [4];
        logic [15:0] rd;
        logic [7:0]  g1, g2;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 16'h00E0, 16'h003C, 16'h0060};
        vecs[1] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 16'h00E0, 16'h00C3, 16'h0060};
        vecs[2] = '{1'b0, 8'h00, 8'h81, 8'h00, 16'h00E0, 16'h0081, 16'h0060};
        vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 16'h00E0, 16'h0080, 16'h0060};

        clks(3);
        reset_n = 1'b1;
        clks(2);
        check("reset MISO_oe", {15'b0, MISO_oe}, 16'h0000);
        check("reset irq", {15'b0, irq}, 16'h0000);
        check("reset MISO", {15'b0, MISO}, 16'h0000);
        check("reset data_to_cpu", data_to_cpu, 16'h0000);
        cpu_read(3'd2, rd);
        check("reset status", rd, 16'h0060);

        // Keep EOP out of the way of the table values.
        cpu_write(3'd6, 16'h00EE);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].prime) cpu_write(3'd1, {8'h00, vecs[v].tx});
            ss_low();
            spi_bits(vecs[v].mosi, 8, g1);
            ss_high();
            check($sformatf("vec%0d miso", v), {8'h00, g1}, {8'h00, vecs[v].exp_miso});
            cpu_read(3'd2, rd);
            check($sformatf("vec%0d status full", v), rd, vecs[v].exp_st_full);
            cpu_read(3'd0, rd);
            check($sformatf("vec%0d rxdata", v), rd, vecs[v].exp_rx);
            cpu_read(3'd2, rd);
            check($sformatf("vec%0d status after", v), rd, vecs[v].exp_st_after);
        end

        // Back-to-back bytes with a mid-byte refill.
        cpu_write(3'd1, 16'h0011);
        ss_low();
        fork
            spi_bits(8'hF0, 8, g1);
            begin
                clks(12);
                cpu_write(3'd1, 16'h0022);
            end
        join
        cpu_read(3'd0, rd);
        check("b2b rx1", rd, 16'h00F0);
        spi_bits(8'h0F, 8, g2);
        ss_high();
        check("b2b miso1", {8'h00, g1}, 16'h0011);
        check("b2b miso2", {8'h00, g2}, 16'h0022);
        cpu_read(3'd0, rd);
        check("b2b rx2", rd, 16'h000F);
        cpu_read(3'd2, rd);
        check("b2b status tmt", rd, 16'h0060);

        // Overrun and underrun.
        ss_low();
        spi_bits(8'h12, 8, g1);
        spi_bits(8'h34, 8, g2);
        ss_high();
        check("underrun miso1", {8'h00, g1}, 16'h0000);
        check("underrun miso2", {8'h00, g2}, 16'h0000);
        cpu_read(3'd2, rd);
        check("overrun status", rd, 16'h01E8);
        cpu_read(3'd0, rd);
        check("overrun rxdata", rd, 16'h0034);
        cpu_read(3'd2, rd);
        check("overrun status after read", rd, 16'h0168);

        // Transmit overrun and error interrupt.
        cpu_write(3'd1, 16'h0055);
        cpu_write(3'd1, 16'h0066);
        cpu_read(3'd2, rd);
        check("toe status", rd, 16'h0118);
        cpu_write(3'd3, 16'h0100);
        clks(2);
        check("irq on E", {15'b0, irq}, 16'h0001);
        cpu_write(3'd2, 16'h0000);
        clks(2);
        check("irq after status clear", {15'b0, irq}, 16'h0000);
        cpu_read(3'd2, rd);
        check("status after clear", rd, 16'h0000);
        cpu_write(3'd3, 16'h0000);

        // SS abort after 4 bits; 0x55 stays consumed.
        ss_low();
        spi_bits(8'hA0, 4, g1);
        ss_high();
        check("abort miso nibble", {12'h000, g1[7:4]}, 16'h0005);
        cpu_read(3'd2, rd);
        check("abort status", rd, 16'h0060);
        ss_low();
        spi_bits(8'h81, 8, g1);
        ss_high();
        check("post-abort miso", {8'h00, g1}, 16'h0000);
        cpu_read(3'd0, rd);
        check("post-abort rxdata", rd, 16'h0081);

        // End of packet.
        cpu_write(3'd6, 16'h007E);
        cpu_read(3'd6, rd);
        check("eop value readback", rd, 16'h007E);
        ss_low();
        spi_bits(8'h7E, 8, g1);
        ss_high();
        cpu_read(3'd0, rd);
        check("eop rxdata", rd, 16'h007E);
        cpu_read(3'd2, rd);
        check("eop status", rd, 16'h0260);
        cpu_write(3'd3, 16'h0200);
        clks(2);
        check("irq on EOP", {15'b0, irq}, 16'h0001);
        cpu_read(3'd3, rd);
        check("control readback", rd, 16'h0200);
        cpu_write(3'd2, 16'h0000);
        clks(2);
        check("irq after EOP clear", {15'b0, irq}, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nios2_spi_slave.md
# nios2_spi_slave

SPI slave (target) with a CPU register port, the far end of the `nios2_spi` master link: an external SPI master drives SCLK/MOSI/SS_n, and this block shifts received bytes into a CPU-readable holding register while shifting out a CPU-supplied byte. The link format matches the master: 8-bit, MSB first, CPOL=0, CPHA=0. All SPI inputs are oversampled in the system clock domain. Register map, status/control bit positions and interrupt scheme are identical to the master, so one driver model serves both ends.

## Interface
- No parameters: DATABITS=8, CPOL=0, CPHA=0, MSB-first are fixed.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- spi_select  in  1  register-port chip select.
- mem_addr  in  3  register address: 0 rxdata (r), 1 txdata (w), 2 status (r/w), 3 control (r/w), 6 end-of-packet value (r/w). Other addresses read 0.
- read_n / write_n  in  1  active-low strobes; each access is two cycles.
- data_from_cpu  in  16  write data.
- data_to_cpu  out  16  registered read data.
- irq  out  1  registered interrupt.
- SCLK, MOSI, SS_n  in  1  SPI bus from the master, asynchronous to clk.
- MISO  out  1  serial data to the master.
- MISO_oe  out  1  high while selected (synchronized SS_n low); pad tri-states MISO otherwise.

## Operation
- Synchronizers: SCLK, MOSI and SS_n each pass through 2 flops. Edges are detected on a third SCLK/SS_n flop: rise = s & ~s_d, fall = ~s & s_d.
- Register port strobes are formed as in the master:
  - rd_strobe / wr_strobe are single-cycle pulses, asserted the cycle after a select with read_n/write_n low.
  - data_to_cpu is registered and is valid on the second cycle.
- Status bits: ROE[3], TOE[4], TMT[5], TRDY[6], RRDY[7], E[8]=ROE|TOE, EOP[9], others 0.
  - TRDY = ~tx_primed.
  - TMT = ~tx_primed & ~busy. busy is high from SS fall until the end of the byte or SS rise.
- Control: interrupt enables at the same bit positions (3,4,6,7,8,9). There is no TMT enable. Reset value is 0.
  - irq_reg <= OR of (status bit & enable) over ROE, TOE, TRDY, RRDY, E, EOP.
- Writes:
  - txdata write with TRDY=1: tx_holding <= data[7:0], tx_primed <= 1.
  - txdata write with TRDY=0: TOE <= 1 and the data is discarded.
  - Any status write clears EOP, RRDY, ROE and TOE.
- Reading rxdata clears RRDY.
- EOP is set in two cases:
  - an rxdata read where rx_holding == eop_value;
  - a txdata write where data[7:0] == eop_value.
- SS fall: bitcnt <= 0, busy <= 1.
  - If tx_primed: shift_reg <= tx_holding, tx_primed <= 0.
  - Otherwise: shift_reg <= 8'h00 (underrun sends zero; no flag).
- SCLK rise while selected: sample the synchronized MOSI into rx_bit, bitcnt <= bitcnt+1.
  - When bitcnt was 7, this completes the byte: rx_holding <= {shift_reg[6:0], MOSI}, RRDY <= 1. If RRDY was already 1, ROE <= 1 (the old data is overwritten).
- SCLK fall while selected:
  - If bitcnt==0, a byte just finished: reload shift_reg from tx_holding if primed (clear primed), else load 8'h00.
  - Otherwise: shift_reg <= {shift_reg[6:0], rx_bit}.
- MISO = shift_reg[7] at all times.
- SS rise: busy <= 0, bitcnt <= 0. A partial byte is discarded: RRDY/rx_holding are unchanged and no flag is set. tx data consumed at SS fall is not restored.
- Simultaneous events in one cycle:
  - A CPU rxdata read and a byte completion: RRDY ends at 1, because completion wins.
  - A status write and a byte completion: RRDY ends at 1 and ROE ends at 0.
  - A txdata write and a shift-register load: the load takes the old holding value, and the new value is primed.

## Timing
- Reset values: data_to_cpu=0, irq=0, MISO=0, MISO_oe=0, RRDY=0, TOE=ROE=EOP=0, tx_primed=0 (TRDY=1, TMT=1), eop_value=0, control=0.
- Input-to-action latency is 3 clk from a pin edge (2 synchronizer flops + edge flop).
- Maximum SCLK frequency is clk/8. Each SCLK high and low phase must be ≥4 clk. SS_n fall to the first SCLK rise must be ≥4 clk so that MISO bit 7 is stable.
- MISO changes at most 4 clk after a SCLK fall pin edge. This is within the half period at the limit above.
- RRDY asserts 3 clk after the 8th SCLK rise pin edge. irq follows 1 clk later.
- Reset asserted mid-transfer returns everything to reset values. After release, the block waits for a fresh SS fall; a transfer in progress at release is ignored until SS_n rises.

## Test plan
- Reset values: after reset, status reads 0x0060 (TRDY=1, TMT=1); MISO_oe=0; irq=0.
- Single-byte exchange:
  - Stimulus: write txdata=0xA5, then the master sends 0x3C at clk/8.
  - Required response: MISO carries 0xA5 MSB first; rxdata reads 0x3C; RRDY set, then cleared by the read.
- Back-to-back bytes:
  - Stimulus: 0x11 is primed; during byte 1, write 0x22; the master sends 0xF0, 0x0F with SS held low.
  - Required response: MISO carries 0x11 then 0x22; after reading 0xF0, rxdata reads 0x0F; TMT=1 at the end.
- Overrun, underrun and TOE:
  - Two bytes received without a read set ROE; rxdata reads the second byte.
  - No tx primed: MISO sends 0x00.
  - Two txdata writes with no transfer: TOE=1.
  - With control=0x0100, irq=1; a status write clears it.
- SS abort: SS_n rises after 4 bits; RRDY stays 0; the next full byte 0x81 is received correctly.
- EOP: set eop_value=0x7E, receive 0x7E, read rxdata; EOP=1; with control=0x0200, irq=1.
